// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor history logic.
//   HIST_W       width of one local history pattern
//   NUM_ENTRIES  number of branch-history-table entries
//   IDX_W        index width into the table
//   bp_update_t  one queued EX-stage resolution {idx, pred, miss}
//   bp_shift()   history update: the actual outcome enters at the MSB
//   bp_ctrl_state_t  update controller states
// ---------------------------------------------------------------------------
package bp_pkg;

    localparam int HIST_W      = 8;
    localparam int NUM_ENTRIES = 16;
    localparam int IDX_W       = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
        logic             miss;
    } bp_update_t;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } bp_ctrl_state_t;

    // A misprediction flips the predicted direction to get the real outcome.
    function automatic logic [HIST_W-1:0] bp_shift(
        input logic [HIST_W-1:0] old,
        input logic              pred,
        input logic              miss
    );
        return {pred ^ miss, old[HIST_W-1:1]};
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// ---------------------------------------------------------------------------
// bp_update_fifo
// Synchronous DEPTH-entry FIFO of pending history updates.
//   clk, rst    clock / asynchronous active-high reset
//   flush       drop all contents (wins over a same-cycle push or pop)
//   push        write push_data when not full
//   push_data   update record to enqueue
//   full        no free slot
//   pop         advance the read pointer when not empty
//   empty       nothing queued
//   head        oldest queued record (valid when !empty)
// ---------------------------------------------------------------------------
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  bp_update_t push_data,
    output logic       full,
    input  logic       pop,
    output logic       empty,
    output bp_update_t head
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty can be told apart
    // when the low bits coincide.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    bp_update_t     mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign head    = mem[rd_ptr[PTR_W-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bht_update_ctrl.sv
// ---------------------------------------------------------------------------
// bht_update_ctrl
// Owns the local branch-history table and schedules every write to it.
// EX resolutions are queued and retired one per cycle as history shifts;
// IF lookups are combinational with forwarding of the retiring update;
// a clear request sweeps the table to zero one entry per cycle.
//   clk, rst     clock / asynchronous active-high reset
//   clear_req    one-cycle pulse: flush queue, zero whole table
//   res_valid    EX resolution valid
//   res_ready    queue can accept (not full)
//   res_idx      table index of the resolved branch
//   res_pred     predicted direction (1 = taken)
//   res_miss     1 = misprediction
//   lk_idx       IF lookup index
//   lk_pattern   history for lk_idx
//   busy         sweeping or updates still queued
//   miss_cnt     saturating count of retired mispredictions
// ---------------------------------------------------------------------------
module bht_update_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [IDX_W-1:0]  res_idx,
    input  logic              res_pred,
    input  logic              res_miss,
    input  logic [IDX_W-1:0]  lk_idx,
    output logic [HIST_W-1:0] lk_pattern,
    output logic              busy,
    output logic [15:0]       miss_cnt
);

    bp_ctrl_state_t    state;
    logic [IDX_W-1:0]  sweep_ptr;
    logic [HIST_W-1:0] bht [NUM_ENTRIES];

    bp_update_t        push_data;
    bp_update_t        head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [HIST_W-1:0] new_pattern;

    assign push_data = '{idx: res_idx, pred: res_pred, miss: res_miss};
    assign res_ready = !fifo_full;
    assign push      = res_valid && !fifo_full;

    // A clear request takes the cycle for itself, so nothing retires then.
    assign pop         = (state == RUN) && !fifo_empty && !clear_req;
    assign new_pattern = bp_shift(bht[head.idx], head.pred, head.miss);
    assign busy        = (state == CLEAR) || !fifo_empty;

    bp_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (clear_req),
        .push      (push),
        .push_data (push_data),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Lookup path: a half-cleared table is never exposed, and an update
    // retiring this cycle to the same entry is forwarded.
    always_comb begin
        lk_pattern = bht[lk_idx];
        if (state == CLEAR) begin
            lk_pattern = '0;
        end else if (pop && (lk_idx == head.idx)) begin
            lk_pattern = new_pattern;
        end
    end

    // Controller: retires queued updates in RUN, sweeps the table in CLEAR.
    // A clear request in either state restarts the sweep from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            sweep_ptr <= '0;
            miss_cnt  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bht[i] <= '0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        sweep_ptr <= '0;
                        miss_cnt  <= '0;
                    end else if (pop) begin
                        bht[head.idx] <= new_pattern;
                        if (head.miss && (miss_cnt != 16'hFFFF)) begin
                            miss_cnt <= miss_cnt + 16'd1;
                        end
                    end
                end
                CLEAR: begin
                    bht[sweep_ptr] <= '0;
                    if (clear_req) begin
                        sweep_ptr <= '0;
                        miss_cnt  <= '0;
                    end else if (sweep_ptr == IDX_W'(NUM_ENTRIES-1)) begin
                        state     <= RUN;
                        sweep_ptr <= '0;
                    end else begin
                        sweep_ptr <= sweep_ptr + IDX_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bht_update_ctrl
// Directed self-checking bench for bht_update_ctrl with hand-computed
// expected history patterns, counters and handshake timing.
// ---------------------------------------------------------------------------
module tb_bht_update_ctrl;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_idx;
    logic        res_pred;
    logic        res_miss;
    logic [3:0]  lk_idx;
    logic [7:0]  lk_pattern;
    logic        busy;
    logic [15:0] miss_cnt;

    int vectors;
    int errors;

    bht_update_ctrl #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_idx    (res_idx),
        .res_pred   (res_pred),
        .res_miss   (res_miss),
        .lk_idx     (lk_idx),
        .lk_pattern (lk_pattern),
        .busy       (busy),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] idx,
                                 input logic pred, input logic miss);
        res_valid = v;
        res_idx   = idx;
        res_pred  = pred;
        res_miss  = miss;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        #1;
        while (busy && n < 64) begin
            tick();
            #1;
            n++;
        end
        if (busy) begin
            checkOutput(tag, 32'd1, 32'd0);
        end
    endtask

    logic [7:0] seq2 [4];
    logic       taken3 [5];

    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        clear_req = 1'b0;
        lk_idx    = 4'd0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();

        // ---- 1: reset values, single mispredicted resolution ----
        #1;
        checkOutput("rst_ready", res_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_lk", lk_pattern, 0);
        checkOutput("rst_miss", miss_cnt, 0);
        rst = 1'b0;
        lk_idx = 4'd3;
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b1);
        #1;
        checkOutput("t1_pre", lk_pattern, 8'h00);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput("t1_fwd", lk_pattern, 8'h80);
        checkOutput("t1_busy", busy, 1);
        tick();
        #1;
        checkOutput("t1_tbl", lk_pattern, 8'h80);
        checkOutput("t1_miss", miss_cnt, 1);
        checkOutput("t1_idle", busy, 0);

        // ---- 2: four back-to-back taken updates on entry 3 ----
        seq2[0] = 8'hC0;
        seq2[1] = 8'hE0;
        seq2[2] = 8'hF0;
        seq2[3] = 8'hF8;
        applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("t2_fwd%0d", i), lk_pattern, seq2[i]);
            tick();
        end
        #1;
        checkOutput("t2_tbl", lk_pattern, 8'hF8);
        checkOutput("t2_miss", miss_cnt, 1);

        // ---- 4: preload all entries, then clear with queued updates ----
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        tick();
        lk_idx = 4'd3;
        #1;
        checkOutput("t4_pre3", lk_pattern, 8'hFC);
        lk_idx = 4'd7;
        #1;
        checkOutput("t4_pre7", lk_pattern, 8'h80);
        applyStimulus(1'b1, 4'd5, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 4'd6, 1'b0, 1'b1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            lk_idx = 4'(j);
            #1;
            checkOutput($sformatf("t4_busy%0d", j), busy, 1);
            checkOutput($sformatf("t4_lk%0d", j), lk_pattern, 0);
            tick();
        end
        #1;
        checkOutput("t4_done", busy, 0);
        checkOutput("t4_miss", miss_cnt, 0);
        for (int j = 0; j < 16; j++) begin
            lk_idx = 4'(j);
            #1;
            checkOutput($sformatf("t4_zero%0d", j), lk_pattern, 0);
        end

        // ---- 5: clear_req at sweep cycle 8 restarts the sweep ----
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int j = 0; j < 7; j++) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int j = 0; j < 8; j++) tick();
        #1;
        checkOutput("t5_still", busy, 1);
        for (int j = 0; j < 7; j++) tick();
        #1;
        checkOutput("t5_last", busy, 1);
        tick();
        #1;
        checkOutput("t5_run", busy, 0);

        // ---- 3: producer held off while pops are suspended by a sweep ----
        taken3[0] = 1'b1;
        taken3[1] = 1'b0;
        taken3[2] = 1'b1;
        taken3[3] = 1'b1;
        taken3[4] = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        begin
            int k;
            int stalls;
            k = 0;
            stalls = 0;
            for (int c = 0; c < 40 && k < 5; c++) begin
                applyStimulus(1'b1, 4'd9, 1'b1, !taken3[k]);
                #1;
                if (c == 4) checkOutput("t3_full", res_ready, 0);
                if (res_ready) k++;
                else stalls++;
                tick();
            end
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
            checkOutput("t3_beats", k, 5);
            checkOutput("t3_stalls", stalls, 13);
        end
        waitIdle("t3_timeout");
        lk_idx = 4'd9;
        #1;
        checkOutput("t3_order", lk_pattern, 8'h68);
        checkOutput("t3_miss", miss_cnt, 2);

        // ---- 6: reset in the middle of a sweep with updates queued ----
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        applyStimulus(1'b1, 4'd1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        checkOutput("t6_busy_pre", busy, 1);
        rst = 1'b1;
        lk_idx = 4'd9;
        #1;
        checkOutput("t6_ready", res_ready, 1);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_tbl9", lk_pattern, 0);
        checkOutput("t6_miss", miss_cnt, 0);
        tick();
        rst = 1'b0;
        lk_idx = 4'd1;
        tick();
        #1;
        checkOutput("t6_idle", busy, 0);
        checkOutput("t6_tbl1", lk_pattern, 0);

        // ---- 7: miss counter saturation ----
        for (int c = 0; c < 65534; c++) begin
            applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        waitIdle("t7_timeout_a");
        checkOutput("t7_fffe", miss_cnt, 16'hFFFE);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        waitIdle("t7_timeout_b");
        checkOutput("t7_ffff", miss_cnt, 16'hFFFF);
        applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
        waitIdle("t7_timeout_c");
        checkOutput("t7_sat", miss_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
